// File: rtl/hdmi_tx_pll_lock_ctrl.sv
// hdmi_tx_pll_lock_ctrl
//
// Sequences the HDMI TX PLL through reset, lock wait, lock debounce and run.
// The lock input is first synchronized into the refclk domain. While waiting
// for lock, a timeout retries the PLL reset. Once the lock has been stable for
// a set time, the video logic is released. Losing lock while running starts
// the whole sequence again.
//
// Ports:
//   refclk        in   reference clock; every flop uses its rising edge
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock flag, asynchronous to refclk
//   force_relock  in   single-cycle request to restart the PLL reset sequence
//   pll_rst       out  PLL reset, high only in RESET_PLL
//   video_rst     out  pixel-domain reset, low only in RUN
//   pll_ready     out  high only in RUN
//   lock_loss_cnt out  saturating count of lock losses seen in RUN
//   retry_cnt     out  saturating count of lock-wait timeouts
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK | waiting for locked_s; times out after LOCK_TIMEOUT cycles
// DEBOUNCE  | locked_s must stay high for STABLE_CYCLES consecutive cycles
// RUN       | PLL stable, video released; any lock drop restarts

module hdmi_tx_pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       video_rst,
    output logic       pll_ready,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] retry_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        DEBOUNCE  = 2'd2,
        RUN       = 2'd3
    } state_t;

    // The counter starts at 0 on entry to a state, so the last cycle of a
    // window of N cycles is the one where the counter reads N-1.
    localparam logic [19:0] RST_LAST     = 20'(RST_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [1:0]  sync_q;
    logic        locked_s;
    logic        loss_evt;
    logic        timeout_evt;

    assign locked_s = sync_q[1];

    // Loss and timeout events are decided before force_relock is applied.
    // A coincident force therefore changes only the destination, and each
    // event is still counted exactly once.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 20'd1;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;

        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = DEBOUNCE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = RESET_PLL;
                    timeout_evt = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt = RESET_PLL;
                    loss_evt  = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
            end
        endcase

        if (force_relock) begin
            state_nxt = RESET_PLL;
        end

        // A forced relock from RESET_PLL to RESET_PLL counts as a fresh entry.
        // RUN has no time limit, so its counter is held at 0.
        if (state_nxt != state || force_relock || state == RUN) begin
            cnt_nxt = 20'd0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q        <= 2'b00;
            state         <= RESET_PLL;
            cnt           <= 20'd0;
            pll_rst       <= 1'b1;
            video_rst     <= 1'b1;
            pll_ready     <= 1'b0;
            lock_loss_cnt <= 8'd0;
            retry_cnt     <= 8'd0;
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            pll_rst   <= (state_nxt == RESET_PLL);
            video_rst <= (state_nxt != RUN);
            pll_ready <= (state_nxt == RUN);
            if (loss_evt && lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
            if (timeout_evt && retry_cnt != 8'hFF) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_tx_pll_lock_ctrl.sv
// Self-checking testbench for hdmi_tx_pll_lock_ctrl.
// Parameters used: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.

module tb_hdmi_tx_pll_lock_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       video_rst;
    logic       pll_ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_cnt;

    int checks = 0;
    int failures = 0;

    hdmi_tx_pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .video_rst    (video_rst),
        .pll_ready    (pll_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .retry_cnt    (retry_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic apply_reset(input logic locked);
        rst          = 1'b1;
        force_relock = 1'b0;
        pll_locked   = locked;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        force_relock = 1'b0;
        tick();
        tick();
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL reset_video_rst got=%b exp=1", video_rst); end
        checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL reset_pll_ready got=%b exp=0", pll_ready); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_lock_loss got=%0d exp=0", lock_loss_cnt); end
        checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt); end
    endtask

    task automatic test_lock_basic();
        int n;
        int m;
        apply_reset(1'b1);
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
        checks++; if (n != 4) begin failures++; $display("FAIL basic_pll_rst_len got=%0d exp=4", n); end
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL basic_video_rst_wait got=%b exp=1", video_rst); end
        // One edge for WAIT_LOCK to see locked_s, then 8 debounce edges.
        m = 0;
        while (video_rst === 1'b1 && m < 50) begin m++; tick(); end
        checks++; if (m != 9) begin failures++; $display("FAIL basic_lock_to_run got=%0d exp=9", m); end
        checks++; if (pll_ready !== 1'b1) begin failures++; $display("FAIL basic_pll_ready got=%b exp=1", pll_ready); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL basic_lock_loss got=%0d exp=0", lock_loss_cnt); end
        checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL basic_retry got=%0d exp=0", retry_cnt); end
    endtask

    task automatic test_timeout();
        int   pulses;
        int   cur_len;
        int   lens[2];
        logic prev;
        apply_reset(1'b0);
        rst = 1'b0;
        pulses = 0;
        cur_len = 0;
        lens[0] = 0;
        lens[1] = 0;
        prev = pll_rst;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                pulses++;
                cur_len = 0;
            end
            if (pll_rst === 1'b1) cur_len++;
            if (pll_rst === 1'b0 && prev === 1'b1 && pulses >= 1 && pulses <= 2) lens[pulses-1] = cur_len;
            prev = pll_rst;
            if (i == 23) begin
                checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL timeout_pre_retry got=%0d exp=0", retry_cnt); end
                checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL timeout_pre_pll_rst got=%b exp=0", pll_rst); end
            end
            if (i == 24) begin
                checks++; if (retry_cnt !== 8'd1) begin failures++; $display("FAIL timeout_first_retry got=%0d exp=1", retry_cnt); end
                checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL timeout_first_pll_rst got=%b exp=1", pll_rst); end
            end
        end
        checks++; if (retry_cnt !== 8'd2) begin failures++; $display("FAIL timeout_retry_60 got=%0d exp=2", retry_cnt); end
        checks++; if (pulses != 2) begin failures++; $display("FAIL timeout_pulses got=%0d exp=2", pulses); end
        checks++; if (lens[0] != 4) begin failures++; $display("FAIL timeout_pulse0_len got=%0d exp=4", lens[0]); end
        checks++; if (lens[1] != 4) begin failures++; $display("FAIL timeout_pulse1_len got=%0d exp=4", lens[1]); end
    endtask

    task automatic test_debounce_glitch();
        int n;
        int m;
        apply_reset(1'b0);
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
        // pll_rst just fell (E4): lock rises, locked_s is seen at E7 and DEBOUNCE starts.
        pll_locked = 1'b1;
        repeat (6) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        // Without the glitch RUN would begin at E15.
        repeat (4) tick();
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL glitch_no_early_run got=%b exp=1", video_rst); end
        m = 0;
        while (video_rst === 1'b1 && m < 40) begin m++; tick(); end
        checks++; if (m != 7) begin failures++; $display("FAIL glitch_run_delay got=%0d exp=7", m); end
        checks++; if (pll_ready !== 1'b1) begin failures++; $display("FAIL glitch_pll_ready got=%b exp=1", pll_ready); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL glitch_lock_loss got=%0d exp=0", lock_loss_cnt); end
    endtask

    // Continues from RUN, as left by test_debounce_glitch.
    task automatic test_run_loss();
        int n;
        pll_locked = 1'b0;
        tick();
        tick();
        checks++; if (video_rst !== 1'b0) begin failures++; $display("FAIL loss_edge2_video_rst got=%b exp=0", video_rst); end
        tick();
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL loss_edge3_video_rst got=%b exp=1", video_rst); end
        checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL loss_pll_ready got=%b exp=0", pll_ready); end
        checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL loss_count got=%0d exp=1", lock_loss_cnt); end
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin n++; tick(); end
        checks++; if (n != 4) begin failures++; $display("FAIL loss_pll_rst_len got=%0d exp=4", n); end
    endtask

    task automatic test_force_relock();
        int n;
        apply_reset(1'b0);
        rst = 1'b0;
        repeat (10) tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_wait_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL force_wait_retry got=%0d exp=0", retry_cnt); end
        // RESET_PLL restarts at E11, WAIT_LOCK starts at E15, and the timeout edge is E35.
        repeat (23) tick();
        checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL force_pre_timeout_retry got=%0d exp=0", retry_cnt); end
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL force_pre_timeout_pll_rst got=%b exp=0", pll_rst); end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++; if (retry_cnt !== 8'd1) begin failures++; $display("FAIL force_timeout_retry got=%0d exp=1", retry_cnt); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_timeout_pll_rst got=%b exp=1", pll_rst); end

        pll_locked = 1'b1;
        n = 0;
        while (video_rst === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (n >= 40) begin failures++; $display("FAIL force_reach_run1 got=timeout exp=run"); end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL force_run_video_rst got=%b exp=1", video_rst); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_run_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL force_run_lock_loss got=%0d exp=0", lock_loss_cnt); end

        n = 0;
        while (video_rst === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (n >= 40) begin failures++; $display("FAIL force_reach_run2 got=timeout exp=run"); end
        pll_locked = 1'b0;
        tick();
        tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL force_coincide_lock_loss got=%0d exp=1", lock_loss_cnt); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_coincide_pll_rst got=%b exp=1", pll_rst); end
    endtask

    // Continues from test_force_relock, where lock_loss_cnt is 1.
    task automatic test_saturate_loss();
        int n;
        int exp_cnt;
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            n = 0;
            while (video_rst === 1'b1 && n < 60) begin n++; tick(); end
            if (n >= 60) begin checks++; failures++; $display("FAIL sat_reach_run iter=%0d got=timeout exp=run", i); end
            pll_locked = 1'b0;
            n = 0;
            while (video_rst === 1'b0 && n < 10) begin n++; tick(); end
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            checks++;
            if (lock_loss_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_loss_step iter=%0d got=%0d exp=%0d", i, lock_loss_cnt, exp_cnt);
            end
        end
        checks++; if (lock_loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_loss_final got=%0d exp=255", lock_loss_cnt); end
    endtask

    task automatic test_saturate_retry();
        apply_reset(1'b0);
        rst = 1'b0;
        // A timeout every 24 cycles gives 262 timeouts in 6300 cycles.
        repeat (6300) tick();
        checks++; if (retry_cnt !== 8'd255) begin failures++; $display("FAIL sat_retry_final got=%0d exp=255", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL sat_retry_lock_loss got=%0d exp=0", lock_loss_cnt); end
    endtask

    task automatic test_rst_in_debounce();
        int n;
        apply_reset(1'b0);
        rst = 1'b0;
        repeat (30) tick();
        pll_locked = 1'b1;
        n = 0;
        while (video_rst === 1'b1 && n < 40) begin n++; tick(); end
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin n++; tick(); end
        repeat (3) tick();
        checks++; if (retry_cnt !== 8'd1) begin failures++; $display("FAIL rstdb_pre_retry got=%0d exp=1", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL rstdb_pre_lock_loss got=%0d exp=1", lock_loss_cnt); end
        checks++; if (video_rst !== 1'b1 || pll_rst !== 1'b0) begin failures++; $display("FAIL rstdb_pre_state got=vr%b pr%b exp=vr1 pr0", video_rst, pll_rst); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rstdb_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (video_rst !== 1'b1) begin failures++; $display("FAIL rstdb_video_rst got=%b exp=1", video_rst); end
        checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL rstdb_pll_ready got=%b exp=0", pll_ready); end
        checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL rstdb_lock_loss got=%0d exp=0", lock_loss_cnt); end
        checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL rstdb_retry got=%0d exp=0", retry_cnt); end
        tick();
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rstdb_hold_pll_rst got=%b exp=1", pll_rst); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_timeout();
        test_debounce_glitch();
        test_run_loss();
        test_force_relock();
        test_saturate_loss();
        test_saturate_retry();
        test_rst_in_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
